// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard scoreboard: tracks in-flight writes after ID and picks
// a registered EX forward select per source, or requests a load-use stall.
module fwd_scoreboard #(
    parameter int REG_LOG = 5,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 3,
    parameter int LAT_W   = 2,
    parameter int CNT_W   = 32,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_LOG*NUM_SRC-1:0] rs_ID,
    input  logic [NUM_SRC-1:0]         rs_used_ID,
    input  logic                       issue_valid,
    input  logic [REG_LOG-1:0]         rd_ID,
    input  logic                       reg_write_ID,
    input  logic [LAT_W-1:0]           lat_ID,
    input  logic                       flush,
    input  logic                       stall_ext,
    output logic                       stall,
    output logic [SEL_W*NUM_SRC-1:0]   fwd_sel_EX,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int MAX_LAT = DEPTH - 2;

    logic                     r_vld [1:DEPTH];
    logic [REG_LOG-1:0]       r_rd  [1:DEPTH];
    logic [LAT_W-1:0]         r_lat [1:DEPTH];
    logic [SEL_W*NUM_SRC-1:0] r_sel;
    logic [CNT_W-1:0]         r_cnt;

    logic [SEL_W*NUM_SRC-1:0] w_sel;
    logic [NUM_SRC-1:0]       w_hit;
    logic                     w_hzd;
    logic                     w_stall;
    logic                     w_issue;
    logic                     w_alloc;
    logic [LAT_W-1:0]         w_eff_lat;

    always_comb begin
        if (int'(lat_ID) > MAX_LAT)
            w_eff_lat = LAT_W'(MAX_LAT);
        else
            w_eff_lat = lat_ID;
    end

    // Scan youngest to oldest; WB stage is skipped since the regfile is write-first.
    always_comb begin
        w_sel = '0;
        w_hit = '0;
        w_hzd = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (!w_hit[i] && r_vld[k] && rs_used_ID[i] &&
                    (rs_ID[i*REG_LOG +: REG_LOG] != '0) &&
                    (r_rd[k] == rs_ID[i*REG_LOG +: REG_LOG])) begin
                    w_hit[i] = 1'b1;
                    if (k >= 1 + int'(r_lat[k]))
                        w_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    else
                        w_hzd = 1'b1;
                end
            end
        end
    end

    assign w_stall = w_hzd & issue_valid & ~flush;
    assign w_issue = issue_valid & ~w_stall & ~flush;
    assign w_alloc = w_issue & reg_write_ID & (rd_ID != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_rd[k]  <= '0;
                r_lat[k] <= '0;
            end
            r_sel <= '0;
            r_cnt <= '0;
        end else if (!stall_ext) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_lat[k] <= r_lat[k-1];
            end
            r_vld[1] <= w_alloc;
            r_rd[1]  <= rd_ID;
            r_lat[1] <= w_eff_lat;
            r_sel    <= w_issue ? w_sel : '0;
            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall      = w_stall;
    assign fwd_sel_EX = r_sel;
    assign stall_cnt  = r_cnt;

endmodule
